// File: rtl/truth_table_scanner_if.sv
// Host/scan-target bundle for truth_table_scanner: control handshake, the
// drive/return path to the function under scan, and the result registers.
interface truth_table_scanner_if #(
   parameter int NIN = 10
);
   logic           start;
   logic           abort;
   logic           ack;
   logic           y_in;
   logic [NIN-1:0] x_out;
   logic           busy;
   logic           done;
   logic [NIN:0]   onset_count;
   logic [NIN-1:0] first_minterm;
   logic           first_valid;

   modport master (
      output start, abort, ack, y_in,
      input  x_out, busy, done, onset_count, first_minterm, first_valid
   );

   modport slave (
      input  start, abort, ack, y_in,
      output x_out, busy, done, onset_count, first_minterm, first_valid
   );
endinterface

// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table scanner: walks x_out through every input vector of a
// combinational function, lets each vector settle, samples y_in and records
// the onset size and the lowest onset minterm.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start; previous results stay readable
// DRIVE  | x_out held while settle_cnt counts down to terminal count
// SAMPLE | one cycle: sample y_in, then advance x_out or finish
// DONE   | results frozen, done=1 until host ack
module truth_table_scanner #(
   parameter int NIN    = 10,
   parameter int SETTLE = 1
) (
   input  logic               clk,
   input  logic               rst,
   truth_table_scanner_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

   // Down-counter reload: DRIVE occupies SETTLE cycles ending at count zero.
   localparam logic [3:0]     SETTLE_LD = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);
   localparam logic [NIN-1:0] X_LAST    = '1;

   state_t         state;
   logic [3:0]     settle_cnt;
   logic [NIN-1:0] x_q;
   logic [NIN:0]   onset_q;
   logic [NIN-1:0] first_q;
   logic           first_vld_q;
   logic           busy_q;
   logic           done_q;

   assign bus.x_out         = x_q;
   assign bus.onset_count   = onset_q;
   assign bus.first_minterm = first_q;
   assign bus.first_valid   = first_vld_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;

   // Scan sequencer with registered busy/done; abort outranks the sample update.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         settle_cnt  <= '0;
         x_q         <= '0;
         onset_q     <= '0;
         first_q     <= '0;
         first_vld_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  onset_q     <= '0;
                  first_q     <= '0;
                  first_vld_q <= 1'b0;
                  x_q         <= '0;
                  settle_cnt  <= SETTLE_LD;
                  busy_q      <= 1'b1;
                  state       <= (SETTLE > 0) ? DRIVE : SAMPLE;
               end
            end
            DRIVE: begin
               if (bus.abort) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else if (settle_cnt == 4'd0) begin
                  state <= SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt - 4'd1;
               end
            end
            SAMPLE: begin
               if (bus.abort) begin
                  busy_q <= 1'b0;
                  state  <= IDLE;
               end else begin
                  if (bus.y_in) begin
                     onset_q <= onset_q + (NIN+1)'(1);
                     if (!first_vld_q) begin
                        first_q     <= x_q;
                        first_vld_q <= 1'b1;
                     end
                  end
                  if (x_q == X_LAST) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= DONE;
                  end else begin
                     x_q        <= x_q + NIN'(1);
                     settle_cnt <= SETTLE_LD;
                     state      <= (SETTLE > 0) ? DRIVE : SAMPLE;
                  end
               end
            end
            DONE: begin
               if (bus.ack) begin
                  done_q <= 1'b0;
                  state  <= IDLE;
               end
            end
            default: begin
               busy_q <= 1'b0;
               done_q <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/truth_table_scanner.md
TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL have parameter NIN, default 10, number of function inputs driven.
REQ-002 SHALL have parameter SETTLE, default 1, range 0..15; idle cycles each input vector is held before y is sampled.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request a full scan; sampled only in IDLE.
REQ-006 SHALL have port abort  input  1  cancel a running scan.
REQ-007 SHALL have port ack  input  1  host acknowledge of a completed result.
REQ-008 SHALL have port x_out  output  NIN  input vector driven to the combinational function under scan; bit i drives input xi.
REQ-009 SHALL have port y_in  input  1  function output, returned from the scanned logic.
REQ-010 SHALL have port busy  output  1  high in DRIVE and SAMPLE.
REQ-011 SHALL have port done  output  1  high in DONE only.
REQ-012 SHALL have port onset_count  output  NIN+1  number of minterms with y_in=1.
REQ-013 SHALL have port first_minterm  output  NIN  lowest x_out value sampled with y_in=1.
REQ-014 SHALL have port first_valid  output  1  first_minterm holds a captured value.

Function
REQ-015 SHALL implement states IDLE, DRIVE, SAMPLE, DONE.
REQ-016 IDLE: start=1 SHALL clear onset_count, first_minterm, first_valid, x_out, and the settle counter, and go to DRIVE (SETTLE>0) or SAMPLE (SETTLE=0) next cycle.
REQ-017 DRIVE SHALL hold x_out stable for exactly SETTLE cycles, then go to SAMPLE.
REQ-018 SAMPLE SHALL last one cycle; if y_in=1, onset_count increments by 1.
REQ-019 SAMPLE with y_in=1 and first_valid=0 SHALL load first_minterm=x_out and set first_valid=1; later hits SHALL NOT change it.
REQ-020 SAMPLE with x_out not all-ones SHALL increment x_out and go to DRIVE (or stay in SAMPLE when SETTLE=0).
REQ-021 SAMPLE with x_out all-ones SHALL go to DONE; x_out SHALL NOT wrap; onset_count reaches 2^NIN without overflow.
REQ-022 Each vector SHALL occupy SETTLE+1 cycles; a full scan SHALL take 2^NIN*(SETTLE+1) cycles from the cycle after start acceptance to the first DONE cycle.
REQ-023 DONE SHALL hold done=1 and all results stable until ack=1, then go to IDLE the next cycle; ack outside DONE SHALL be ignored.
REQ-024 start while busy or in DONE SHALL be ignored.
REQ-025 abort=1 in DRIVE or SAMPLE SHALL go to IDLE next cycle without asserting done; partial results SHALL be retained; abort has priority over the SAMPLE update in the same cycle.
REQ-026 abort in IDLE or DONE SHALL be ignored.
REQ-027 Results SHALL remain readable in IDLE until the next accepted start.

Reset
REQ-028 rst=1 SHALL immediately force IDLE, x_out=0, onset_count=0, first_minterm=0, first_valid=0, busy=0, done=0, regardless of clk.
REQ-029 Reset mid-scan SHALL discard the scan; no done pulse SHALL follow deassertion.

Verification
REQ-030 y_in tied 0, SETTLE=1, start pulse -> done after 2048 cycles, onset_count=0, first_valid=0.
REQ-031 y_in tied 1, SETTLE=0 -> done after 1024 cycles, onset_count=1024, first_minterm=0, first_valid=1.
REQ-032 y_in = x0&x9, SETTLE=2 -> done after 3072 cycles, onset_count=256, first_minterm=513.
REQ-033 y_in = ~x1&~x3&~x4&~x5&x6&x7&(x0 ? x2&x9 : x8), SETTLE=1 -> onset_count=6, first_minterm=448.
REQ-034 abort at cycle 100, then second start with y_in tied 1 -> no done after abort; second scan reports onset_count=1024; start pulses during scan ignored.
REQ-035 rst asserted mid-scan between clock edges -> outputs zero before next clk edge; done stays 0 until a new start completes.
